rv_wb_arbiter: RTL and testbench

RV_WB_ARBITER -- requirements
Module: rv_wb_arbiter

---
 rtl/rv_wb_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_rv_wb_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rv_wb_arbiter
// Description : Register-file write-port arbiter between the pipeline
//               writeback and a 2-entry queue of long-latency results.
//               Optional starvation drain: define RV_WB_STARVE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_flush,
    input  logic        i_pipe_valid,
    input  logic [4:0]  i_pipe_rd,
    input  logic [31:0] i_pipe_data,
    output logic        o_pipe_stall,
    input  logic        i_ext_valid,
    input  logic [4:0]  i_ext_rd,
    input  logic [31:0] i_ext_data,
    output logic        o_ext_ready,
    output logic        o_write_op,
    output logic [4:0]  o_rd,
    output logic [31:0] o_data,
    output logic [31:0] o_pend_mask
);

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_DRAIN  = 1'b1
    } state_t;

    if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_limit
        $error("rv_wb_arbiter: STARVE_LIMIT must be within 1..15");
    end

    state_t           state_q, state_d;
    logic [1:0]       count_q, count_d;
    logic [1:0][4:0]  ent_rd_q, ent_rd_d;
    logic [1:0][31:0] ent_data_q, ent_data_d;
    logic [1:0]       ent_vld_q, ent_vld_d;
    logic             write_op_q, write_op_d;
    logic [4:0]       rd_q, rd_d;
    logic [31:0]      data_q, data_d;

    logic             pipe_live;
    logic             ext_push;
    logic             pop;
    logic             starve_fire;

    assign o_pipe_stall = (state_q == ST_DRAIN);
    assign o_ext_ready  = (count_q != 2'd2);
    assign o_write_op   = write_op_q;
    assign o_rd         = rd_q;
    assign o_data       = data_q;

    always_comb begin
        pipe_live = i_pipe_valid & ~i_flush & ~o_pipe_stall & (i_pipe_rd != 5'd0);
        ext_push  = i_ext_valid & o_ext_ready & (i_ext_rd != 5'd0);
        // With an empty queue a pop takes the incoming result straight through.
        pop       = ~pipe_live & ((count_q != 2'd0) | ext_push);
    end

    always_comb begin
        o_pend_mask = 32'd0;
        for (int i = 0; i < 2; i++) begin
            if (ent_vld_q[i]) begin
                o_pend_mask[ent_rd_q[i]] = 1'b1;
            end
        end
    end

`ifdef RV_WB_STARVE_EN
    localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_q, starve_d;

    always_comb begin
        if ((count_q == 2'd0) || pop) begin
            starve_d = 4'd0;
        end else if (starve_q != 4'hF) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = starve_q;
        end
        starve_fire = (starve_d >= C_STARVE_LIMIT);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign starve_fire = 1'b0;
`endif

    always_comb begin
        ent_rd_d   = ent_rd_q;
        ent_data_d = ent_data_q;
        ent_vld_d  = ent_vld_q;
        count_d    = count_q;
        write_op_d = 1'b0;
        rd_d       = rd_q;
        data_d     = data_q;
        state_d    = state_q;

        if (pipe_live) begin
            write_op_d = 1'b1;
            rd_d       = i_pipe_rd;
            data_d     = i_pipe_data;
            // Younger pipeline result supersedes any queued write to the same rd.
            for (int i = 0; i < 2; i++) begin
                if (ent_vld_q[i] && (ent_rd_q[i] == i_pipe_rd)) begin
                    ent_vld_d[i] = 1'b0;
                end
            end
        end else if (pop) begin
            if (count_q != 2'd0) begin
                if (ent_vld_q[0]) begin
                    write_op_d = 1'b1;
                    rd_d       = ent_rd_q[0];
                    data_d     = ent_data_q[0];
                end
                ent_rd_d[0]   = ent_rd_q[1];
                ent_data_d[0] = ent_data_q[1];
                ent_vld_d[0]  = ent_vld_q[1];
                ent_vld_d[1]  = 1'b0;
                count_d       = count_q - 2'd1;
            end else begin
                write_op_d = 1'b1;
                rd_d       = i_ext_rd;
                data_d     = i_ext_data;
            end
        end

        if (ext_push && !(pop && (count_q == 2'd0))) begin
            if (count_d == 2'd0) begin
                ent_rd_d[0]   = i_ext_rd;
                ent_data_d[0] = i_ext_data;
                ent_vld_d[0]  = 1'b1;
            end else begin
                ent_rd_d[1]   = i_ext_rd;
                ent_data_d[1] = i_ext_data;
                ent_vld_d[1]  = 1'b1;
            end
            count_d = count_d + 2'd1;
        end

        unique case (state_q)
            ST_NORMAL: begin
                if (((count_q == 2'd2) && i_ext_valid) || starve_fire) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (count_d == 2'd0) begin
                    state_d = ST_NORMAL;
                end
            end
            default: state_d = ST_NORMAL;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ST_NORMAL;
            count_q    <= 2'd0;
            ent_rd_q   <= '0;
            ent_data_q <= '0;
            ent_vld_q  <= 2'b00;
            write_op_q <= 1'b0;
            rd_q       <= 5'd0;
            data_q     <= 32'd0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            ent_rd_q   <= ent_rd_d;
            ent_data_q <= ent_data_d;
            ent_vld_q  <= ent_vld_d;
            write_op_q <= write_op_d;
            rd_q       <= rd_d;
            data_q     <= data_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_wb_arbiter
// Description : Directed-vector bench for rv_wb_arbiter (default build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_wb_arbiter;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_flush;
    logic        i_pipe_valid;
    logic [4:0]  i_pipe_rd;
    logic [31:0] i_pipe_data;
    logic        o_pipe_stall;
    logic        i_ext_valid;
    logic [4:0]  i_ext_rd;
    logic [31:0] i_ext_data;
    logic        o_ext_ready;
    logic        o_write_op;
    logic [4:0]  o_rd;
    logic [31:0] o_data;
    logic [31:0] o_pend_mask;

    int n_vec = 0;
    int n_err = 0;

    rv_wb_arbiter #(.STARVE_LIMIT(8)) u_dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_flush      (i_flush),
        .i_pipe_valid (i_pipe_valid),
        .i_pipe_rd    (i_pipe_rd),
        .i_pipe_data  (i_pipe_data),
        .o_pipe_stall (o_pipe_stall),
        .i_ext_valid  (i_ext_valid),
        .i_ext_rd     (i_ext_rd),
        .i_ext_data   (i_ext_data),
        .o_ext_ready  (o_ext_ready),
        .o_write_op   (o_write_op),
        .o_rd         (o_rd),
        .o_data       (o_data),
        .o_pend_mask  (o_pend_mask)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pipe(input logic v, input logic [4:0] rd, input logic [31:0] d);
        i_pipe_valid = v;
        i_pipe_rd    = rd;
        i_pipe_data  = d;
    endtask

    task automatic ext(input logic v, input logic [4:0] rd, input logic [31:0] d);
        i_ext_valid = v;
        i_ext_rd    = rd;
        i_ext_data  = d;
    endtask

    task automatic idle();
        pipe(1'b0, 5'd0, 32'd0);
        ext(1'b0, 5'd0, 32'd0);
        i_flush = 1'b0;
    endtask

    task automatic check_wr(input string tag, input logic op, input logic [4:0] rd,
                            input logic [31:0] d);
        check({tag, ".op"},   32'(o_write_op), 32'(op));
        check({tag, ".rd"},   32'(o_rd),       32'(rd));
        check({tag, ".data"}, o_data,          d);
    endtask

    initial begin
        i_reset_n = 1'b0;
        idle();
        tick();
        tick();
        check_wr("rst", 1'b0, 5'd0, 32'd0);
        check("rst.pend",  o_pend_mask,        32'd0);
        check("rst.stall", 32'(o_pipe_stall),  32'd0);
        check("rst.ready", 32'(o_ext_ready),   32'd1);
        i_reset_n = 1'b1;
        tick();

        // Lone external result with an idle pipeline.
        ext(1'b1, 5'd5, 32'hAAAA_0001);
        tick();
        idle();
        check_wr("ext1", 1'b1, 5'd5, 32'hAAAA_0001);
        check("ext1.pend", o_pend_mask, 32'd0);
        tick();
        check_wr("ext1.idle", 1'b0, 5'd5, 32'hAAAA_0001);

        // Fill the queue under pipeline pressure, then force a drain.
        pipe(1'b1, 5'd1, 32'h100); ext(1'b1, 5'd3, 32'h33);
        tick();
        check_wr("fill.a", 1'b1, 5'd1, 32'h100);
        check("fill.a.pend", o_pend_mask, 32'h8);
        pipe(1'b1, 5'd2, 32'h200); ext(1'b1, 5'd4, 32'h44);
        tick();
        check_wr("fill.b", 1'b1, 5'd2, 32'h200);
        check("fill.b.pend",  o_pend_mask,       32'h18);
        check("fill.b.ready", 32'(o_ext_ready),  32'd0);
        check("fill.b.stall", 32'(o_pipe_stall), 32'd0);
        pipe(1'b1, 5'd6, 32'h600); ext(1'b1, 5'd9, 32'h99);
        tick();
        check_wr("fill.c", 1'b1, 5'd6, 32'h600);
        check("drain.enter", 32'(o_pipe_stall), 32'd1);
        pipe(1'b1, 5'd6, 32'h700); ext(1'b0, 5'd0, 32'd0);
        tick();
        check_wr("drain.1", 1'b1, 5'd3, 32'h33);
        check("drain.1.stall", 32'(o_pipe_stall), 32'd1);
        check("drain.1.pend",  o_pend_mask,       32'h10);
        tick();
        check_wr("drain.2", 1'b1, 5'd4, 32'h44);
        check("drain.2.stall", 32'(o_pipe_stall), 32'd0);
        check("drain.2.pend",  o_pend_mask,       32'd0);
        tick();
        check_wr("drain.resume", 1'b1, 5'd6, 32'h700);
        idle();

        // WAW: pipeline write to a queued rd kills the queued entry.
        pipe(1'b1, 5'd1, 32'h11); ext(1'b1, 5'd7, 32'h77);
        tick();
        check("waw.pend", o_pend_mask, 32'h80);
        pipe(1'b1, 5'd7, 32'h1234); ext(1'b0, 5'd0, 32'd0);
        tick();
        idle();
        check_wr("waw.pipe", 1'b1, 5'd7, 32'h1234);
        check("waw.pend.clr", o_pend_mask, 32'd0);
        tick();
        check_wr("waw.killed", 1'b0, 5'd7, 32'h1234);
        tick();
        check_wr("waw.quiet", 1'b0, 5'd7, 32'h1234);

        // x0 destinations and flush never write.
        ext(1'b1, 5'd0, 32'hDEAD);
        tick();
        check_wr("ext.x0", 1'b0, 5'd7, 32'h1234);
        check("ext.x0.pend",  o_pend_mask,      32'd0);
        check("ext.x0.ready", 32'(o_ext_ready), 32'd1);
        idle();
        pipe(1'b1, 5'd0, 32'hBEEF);
        tick();
        check_wr("pipe.x0", 1'b0, 5'd7, 32'h1234);
        pipe(1'b1, 5'd8, 32'h8888); i_flush = 1'b1;
        tick();
        idle();
        check_wr("flush", 1'b0, 5'd7, 32'h1234);

        // Same-cycle ext and pipeline to one rd: ext result is younger and kept.
        pipe(1'b1, 5'd12, 32'hC0DE); ext(1'b1, 5'd12, 32'hE12);
        tick();
        idle();
        check_wr("same.pipe", 1'b1, 5'd12, 32'hC0DE);
        check("same.pend", o_pend_mask, 32'h1000);
        tick();
        check_wr("same.ext", 1'b1, 5'd12, 32'hE12);
        check("same.pend.clr", o_pend_mask, 32'd0);

        // Queued entry under continuous pipeline writes.
        pipe(1'b1, 5'd14, 32'h0); ext(1'b1, 5'd13, 32'hD13);
        tick();
        ext(1'b0, 5'd0, 32'd0);
        for (int i = 1; i < 12; i++) begin
            pipe(1'b1, 5'd14, 32'(i));
            tick();
        end
`ifdef RV_WB_STARVE_EN
        check("starve.pend", o_pend_mask, 32'd0);
        idle();
        tick();
`else
        check("starve.pend",  o_pend_mask,       32'h2000);
        check("starve.stall", 32'(o_pipe_stall), 32'd0);
        idle();
        tick();
        check_wr("starve.late", 1'b1, 5'd13, 32'hD13);
`endif
        check("starve.empty", o_pend_mask, 32'd0);

        // Asynchronous reset in the middle of a full-queue drain.
        pipe(1'b1, 5'd1, 32'h1); ext(1'b1, 5'd20, 32'h20);
        tick();
        pipe(1'b1, 5'd2, 32'h2); ext(1'b1, 5'd21, 32'h21);
        tick();
        pipe(1'b1, 5'd3, 32'h3); ext(1'b1, 5'd22, 32'h22);
        tick();
        check("mid.stall", 32'(o_pipe_stall), 32'd1);
        check("mid.pend",  o_pend_mask,       32'h0030_0000);
        #1;
        i_reset_n = 1'b0;
        #1;
        check_wr("arst", 1'b0, 5'd0, 32'd0);
        check("arst.pend",  o_pend_mask,       32'd0);
        check("arst.stall", 32'(o_pipe_stall), 32'd0);
        check("arst.ready", 32'(o_ext_ready),  32'd1);
        idle();
        tick();
        i_reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post.op", 32'(o_write_op), 32'd0);
        end
        check("post.pend", o_pend_mask, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
